// File: rtl/dccm_arb.sv
// Arbitrates the single DCCM port between the LSU (fixed priority) and a DMA/loader port,
// with a starvation guard for DMA. Optional statistics counters: define DCCM_ARB_STATS_EN.
module dccm_arb #(
  parameter int unsigned STARVE_LIMIT = 8
`ifdef DCCM_ARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dccm_wr_en,
  output logic        dccm_rd_en,
  output logic [31:0] dccm_wr_addr,
  output logic [31:0] dccm_rd_addr,
  output logic [31:0] dccm_wr_data,
  input  logic [31:0] dccm_rd_data
`ifdef DCCM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_lsu_grants,
  output logic [CNT_W-1:0] stat_dma_grants,
  output logic [CNT_W-1:0] stat_conflicts,
  output logic [CNT_W-1:0] stat_starve_events
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {LSU_PRI, DMA_PRI} pri_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_LSU, OWN_DMA} owner_t;

  pri_t       pri, pri_nxt;
  owner_t     rd_owner, owner_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       win_any, win_we;
  logic [31:0] win_addr, win_wdata;

  always_comb begin
    lsu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    wait_nxt = '0;
    pri_nxt  = pri;
    if (!rst) begin
      case (pri)
        LSU_PRI: begin
          lsu_gnt = lsu_req;
          dma_gnt = dma_req & ~lsu_req;
        end
        DMA_PRI: begin
          dma_gnt = dma_req;
          lsu_gnt = lsu_req & ~dma_req;
        end
        default: ;
      endcase
    end
    if (dma_req && !dma_gnt)
      wait_nxt = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 8'd1;
    // DMA_PRI only ever lasts until the owed grant is delivered or the request is withdrawn
    case (pri)
      LSU_PRI: if (wait_nxt == LIMIT) pri_nxt = DMA_PRI;
      DMA_PRI: if (dma_gnt || !dma_req) pri_nxt = LSU_PRI;
      default: pri_nxt = LSU_PRI;
    endcase
  end

  always_comb begin
    win_any   = lsu_gnt | dma_gnt;
    win_we    = lsu_gnt ? lsu_we : dma_we;
    win_addr  = lsu_gnt ? lsu_addr : dma_addr;
    win_wdata = lsu_gnt ? lsu_wdata : dma_wdata;

    dccm_wr_en   = win_any & win_we;
    dccm_rd_en   = win_any & ~win_we;
    dccm_wr_addr = dccm_wr_en ? win_addr : '0;
    dccm_wr_data = dccm_wr_en ? win_wdata : '0;
    dccm_rd_addr = dccm_rd_en ? win_addr : '0;

    owner_nxt = OWN_NONE;
    if (dccm_rd_en) owner_nxt = lsu_gnt ? OWN_LSU : OWN_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri      <= LSU_PRI;
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      pri      <= pri_nxt;
      wait_cnt <= wait_nxt;
      rd_owner <= owner_nxt;
    end
  end

  // Gating with rst suppresses data for a read granted just before reset asserted
  assign lsu_rvalid = !rst && (rd_owner == OWN_LSU);
  assign dma_rvalid = !rst && (rd_owner == OWN_DMA);
  assign lsu_rdata  = lsu_rvalid ? dccm_rd_data : '0;
  assign dma_rdata  = dma_rvalid ? dccm_rd_data : '0;

`ifdef DCCM_ARB_STATS_EN
  logic starve_evt;
  assign starve_evt = !rst && (pri == LSU_PRI) && (pri_nxt == DMA_PRI);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lsu_grants    <= '0;
      stat_dma_grants    <= '0;
      stat_conflicts     <= '0;
      stat_starve_events <= '0;
    end else begin
      if (lsu_gnt)            stat_lsu_grants    <= stat_lsu_grants + CNT_W'(1);
      if (dma_gnt)            stat_dma_grants    <= stat_dma_grants + CNT_W'(1);
      if (lsu_req && dma_req) stat_conflicts     <= stat_conflicts + CNT_W'(1);
      if (starve_evt)         stat_starve_events <= stat_starve_events + CNT_W'(1);
    end
  end
`endif

endmodule
